// File: rtl/cdc_2phase_rr_arb_if.sv
// Handshake bundle between NumIn same-domain requesters, the round-robin arbiter
// and the single registered output that feeds a cdc_2phase source port.
interface cdc_2phase_rr_arb_if #(
    parameter int unsigned NumIn = 4,
    parameter type         T     = logic,
    parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
);
    T                  inp_data_i [NumIn];
    logic [NumIn-1:0]  inp_valid_i;
    logic [NumIn-1:0]  inp_ready_o;
    T                  oup_data_o;
    logic [IdxW-1:0]   oup_idx_o;
    logic              oup_valid_o;
    logic              oup_ready_i;

    modport slave (
        input  inp_data_i, inp_valid_i, oup_ready_i,
        output inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
    );

    modport master (
        output inp_data_i, inp_valid_i, oup_ready_i,
        input  inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
    );
endinterface

// File: rtl/cdc_2phase_rr_arb.sv
// Round-robin arbiter sharing one registered valid/ready output (tagged with the
// requester index) among NumIn requesters; stalls in FULL while the CDC is busy.
module cdc_2phase_rr_arb #(
    parameter int unsigned NumIn = 4,
    parameter type         T     = logic,
    parameter int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    cdc_2phase_rr_arb_if.slave       bus
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e           r_state, w_state_nxt;
    logic [IdxW-1:0]  r_idx,   w_idx_nxt;
    T                 r_data,  w_data_nxt;
    logic [IdxW-1:0]  r_prio,  w_prio_nxt;

    logic [IdxW-1:0]  w_gnt;
    logic             w_any_req;
    logic             w_can_load;
    logic [NumIn-1:0] w_inp_ready;

    assign w_any_req  = |bus.inp_valid_i;
    assign w_can_load = (r_state == S_EMPTY) || bus.oup_ready_i;

    // Scan offsets from the far end down so the candidate nearest r_prio wins.
    always_comb begin
        int unsigned w_sum;
        w_gnt = '0;
        w_sum = 0;
        for (int unsigned k = NumIn; k > 0; k--) begin
            w_sum = 32'(r_prio) + (k - 1);
            if (w_sum >= NumIn) w_sum = w_sum - NumIn;
            if (bus.inp_valid_i[IdxW'(w_sum)]) w_gnt = IdxW'(w_sum);
        end
    end

    // Reset gates the acknowledge so no requester sees ready while held in reset.
    always_comb begin
        w_inp_ready = '0;
        for (int unsigned i = 0; i < NumIn; i++) begin
            w_inp_ready[i] = rst_ni && w_any_req && w_can_load && (w_gnt == IdxW'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_prio_nxt  = r_prio;
        if (w_any_req && w_can_load) begin
            w_state_nxt = S_FULL;
            w_idx_nxt   = w_gnt;
            w_data_nxt  = bus.inp_data_i[w_gnt];
            w_prio_nxt  = (w_gnt == IdxW'(NumIn - 1)) ? '0 : w_gnt + IdxW'(1);
        end else if ((r_state == S_FULL) && bus.oup_ready_i) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_EMPTY;
            r_idx   <= '0;
            r_data  <= '0;
            r_prio  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    assign bus.inp_ready_o = w_inp_ready;
    assign bus.oup_valid_o = (r_state == S_FULL);
    assign bus.oup_idx_o   = r_idx;
    assign bus.oup_data_o  = r_data;

endmodule

// File: tb/tb_cdc_2phase_rr_arb.sv
// Scoreboard bench for cdc_2phase_rr_arb: directed phases push expected (idx, data)
// items; a negedge monitor pops and compares every output handshake.
module tb_cdc_2phase_rr_arb;

    localparam int unsigned N = 4;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } item_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    item_t exp_q [$];

    cdc_2phase_rr_arb_if #(.NumIn(N), .T(logic [7:0])) bus ();

    cdc_2phase_rr_arb #(.NumIn(N), .T(logic [7:0])) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mk(input int unsigned i, input int unsigned n);
        logic [1:0] ii;
        logic [3:0] nn;
        ii = 2'(i);
        nn = 4'(n);
        return {ii, 2'b00, nn};
    endfunction

    task automatic push(input int unsigned i, input logic [7:0] d);
        item_t e;
        e.idx  = 2'(i);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT offers an item that is accepted, it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.oup_valid_o && bus.oup_ready_i) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected", {22'd0, bus.oup_idx_o, bus.oup_data_o}, 32'hFFFF_FFFF);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                check("mon_idx", 32'(bus.oup_idx_o), 32'(e.idx));
                check("mon_data", 32'(bus.oup_data_o), 32'(e.data));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] acc;
        logic         cons;
        int unsigned  cnt [N];
        int unsigned  dwait;
        int           last_g;
        int           g;
        int unsigned  total;

        tests = 0;
        fails = 0;

        // Reset with every requester valid.
        rst_n = 1'b0;
        bus.oup_ready_i = 1'b1;
        bus.inp_valid_i = '1;
        for (int i = 0; i < int'(N); i++) bus.inp_data_i[i] = 8'hA0 + 8'(i);
        @(negedge clk);
        check("rst_valid", 32'(bus.oup_valid_o), 0);
        check("rst_idx", 32'(bus.oup_idx_o), 0);
        check("rst_data", 32'(bus.oup_data_o), 0);
        check("rst_inp_ready", 32'(bus.inp_ready_o), 0);

        // Round-robin from requester 0 with wrap 3 -> 0.
        for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i));
        push(0, 8'hA0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        bus.inp_valid_i = '0;
        tick();
        @(negedge clk);
        check("rr_drained", 32'(bus.oup_valid_o), 0);
        check("rr_q_empty", exp_q.size(), 0);

        // Skip: move prio to 2 via requester 1, then only 1 and 3 valid.
        tick();
        bus.inp_valid_i = 4'b0010;
        bus.inp_data_i[1] = 8'hB1;
        push(1, 8'hB1);
        push(3, 8'hC3);
        push(1, 8'hC1);
        push(3, 8'hC3);
        tick();
        bus.inp_valid_i = 4'b1010;
        bus.inp_data_i[1] = 8'hC1;
        bus.inp_data_i[3] = 8'hC3;
        @(negedge clk);
        check("skip_gnt3_a", 32'(bus.inp_ready_o), 32'b1000);
        tick();
        @(negedge clk);
        check("skip_gnt1", 32'(bus.inp_ready_o), 32'b0010);
        tick();
        @(negedge clk);
        check("skip_gnt3_b", 32'(bus.inp_ready_o), 32'b1000);
        tick();
        bus.inp_valid_i = '0;
        tick();
        @(negedge clk);
        check("skip_drained", 32'(bus.oup_valid_o), 0);
        check("skip_q_empty", exp_q.size(), 0);

        // Stall: hold (2,55) for 5 cycles with requester 0 waiting, then no-bubble handover.
        tick();
        bus.inp_valid_i = 4'b0100;
        bus.inp_data_i[2] = 8'h55;
        push(2, 8'h55);
        push(0, 8'h11);
        tick();
        bus.oup_ready_i = 1'b0;
        bus.inp_valid_i = 4'b0001;
        bus.inp_data_i[0] = 8'h11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.oup_valid_o), 1);
            check("stall_idx", 32'(bus.oup_idx_o), 2);
            check("stall_data", 32'(bus.oup_data_o), 32'h55);
            check("stall_inp_ready", 32'(bus.inp_ready_o), 0);
            tick();
        end
        bus.oup_ready_i = 1'b1;
        @(negedge clk);
        check("stall_release_ready", 32'(bus.inp_ready_o), 32'b0001);
        tick();
        bus.inp_valid_i = '0;
        @(negedge clk);
        check("stall_no_bubble_valid", 32'(bus.oup_valid_o), 1);
        check("stall_no_bubble_idx", 32'(bus.oup_idx_o), 0);
        tick();
        @(negedge clk);
        check("stall_q_empty", exp_q.size(), 0);

        // Reset mid-operation: stalled (1,77) must vanish; arbitration restarts at 0.
        tick();
        bus.oup_ready_i = 1'b0;
        bus.inp_valid_i = 4'b0010;
        bus.inp_data_i[1] = 8'h77;
        tick();
        bus.inp_valid_i = '0;
        @(negedge clk);
        check("mid_full", 32'(bus.oup_valid_o), 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(bus.oup_valid_o), 0);
        check("mid_async_data", 32'(bus.oup_data_o), 0);
        check("mid_async_idx", 32'(bus.oup_idx_o), 0);
        #4 rst_n = 1'b1;
        bus.oup_ready_i = 1'b1;
        bus.inp_valid_i = '1;
        for (int i = 0; i < int'(N); i++) bus.inp_data_i[i] = 8'hA0 + 8'(i);
        push(0, 8'hA0);
        #1;
        check("mid_restart_gnt0", 32'(bus.inp_ready_o), 32'b0001);
        tick();
        bus.inp_valid_i = '0;
        tick();
        @(negedge clk);
        check("mid_q_empty", exp_q.size(), 0);

        // Stream: 4 x 16 tagged items, sink drops ready for 3 cycles after each item.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 16; n++)
            for (int i = 0; i < int'(N); i++) push(i, mk(i, n));
        for (int i = 0; i < int'(N); i++) begin
            cnt[i] = 0;
            bus.inp_data_i[i] = mk(i, 0);
        end
        bus.inp_valid_i = '1;
        bus.oup_ready_i = 1'b1;
        dwait  = 0;
        last_g = -1;
        total  = 0;
        for (int c = 0; c < 3000 && (total < 64 || bus.oup_valid_o); c++) begin
            @(negedge clk);
            acc  = bus.inp_valid_i & bus.inp_ready_o;
            cons = bus.oup_valid_o && bus.oup_ready_i;
            if (acc != '0) begin
                g = 0;
                for (int i = 0; i < int'(N); i++) if (acc[i]) g = i;
                check("fair_repeat", 32'((g == last_g) && ((bus.inp_valid_i & ~acc) != '0)), 0);
                last_g = g;
            end
            tick();
            for (int i = 0; i < int'(N); i++) begin
                if (acc[i]) begin
                    cnt[i]++;
                    total++;
                    if (cnt[i] < 16) bus.inp_data_i[i] = mk(i, cnt[i]);
                    else bus.inp_valid_i[i] = 1'b0;
                end
            end
            if (cons) begin
                dwait = 3;
                bus.oup_ready_i = 1'b0;
            end else if (dwait > 0) begin
                dwait--;
                if (dwait == 0) bus.oup_ready_i = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) check("stream_count", cnt[i], 16);
        check("stream_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
